// File: rtl/pe_pkg.sv
// Shared definitions for the bit-serial PE accumulator: controller states and
// the width helpers that size the column sum and the signed accumulator.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } pe_state_e;

    function automatic int sum_bits(input int adc_bits, input int n_row_sa);
        return adc_bits + $clog2(n_row_sa);
    endfunction

    // One extra bit beyond the shifted sum keeps signed results representable.
    function automatic int acc_bits(input int adc_bits, input int n_row_sa, input int max_prec);
        return sum_bits(adc_bits, n_row_sa) + max_prec + 1;
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Unsigned reduction of the ADC codes from the SAs stacked along one output
// column into a single column sum.
module pe_adder_tree
    import pe_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = sum_bits(IN_BITS, N_IN)
) (
    input  logic [N_IN-1:0][IN_BITS-1:0] i_codes,
    output logic [OUT_BITS-1:0]          o_sum
);

    // Zero-extended accumulation of all stacked SA codes.
    always_comb begin
        o_sum = {OUT_BITS{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            o_sum = o_sum + OUT_BITS'(i_codes[i]);
        end
    end

endmodule

// File: rtl/pe_bitserial_acc.sv
// Bit-serial PE controller: streams input bit-planes LSB first to the
// sub-arrays, waits for every SA conversion, and shift-accumulates the sums.
module pe_bitserial_acc
    import pe_pkg::*;
#(
    parameter int  N_SA_ROWS = 256,
    parameter int  N_ROW_SA  = 4,
    parameter int  N_COL_SA  = 4,
    parameter int  N_SA_COLS = N_SA_ROWS,
    parameter int  ADC_BITS  = 4,
    parameter int  MAX_PREC  = 8,
    localparam int SUM_BITS  = sum_bits(ADC_BITS, N_ROW_SA),
    localparam int ACC_BITS  = acc_bits(ADC_BITS, N_ROW_SA, MAX_PREC),
    localparam int PREC_W    = $clog2(MAX_PREC + 1)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    in_valid_i,
    output logic                                                    in_ready_o,
    input  logic [N_ROW_SA*N_SA_ROWS-1:0][MAX_PREC-1:0]             in_data_i,
    input  logic [PREC_W-1:0]                                       prec_i,
    input  logic                                                    signed_i,
    output logic [N_ROW_SA-1:0][N_SA_ROWS-1:0]                      sa_bit_o,
    output logic [N_COL_SA-1:0][N_ROW_SA-1:0]                       sa_start_o,
    input  logic [N_COL_SA-1:0][N_ROW_SA-1:0]                       sa_done_i,
    input  logic [N_COL_SA-1:0][N_ROW_SA-1:0][N_SA_COLS-1:0][ADC_BITS-1:0] sa_comp_i,
    output logic                                                    out_valid_o,
    input  logic                                                    out_ready_i,
    output logic signed [N_COL_SA-1:0][N_SA_COLS-1:0][ACC_BITS-1:0] out_data_o
);

    localparam int N_IN = N_ROW_SA * N_SA_ROWS;
    localparam int B_W  = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;

    pe_state_e                                          r_state;
    pe_state_e                                          w_next_state;
    logic [N_IN-1:0][MAX_PREC-1:0]                      r_data;
    logic [PREC_W-1:0]                                  r_prec;
    logic                                               r_signed;
    logic [B_W-1:0]                                     r_b;
    logic [N_COL_SA-1:0][N_ROW_SA-1:0]                  r_sticky;
    logic [N_COL_SA-1:0][N_SA_COLS-1:0][ACC_BITS-1:0]   r_acc;
    logic                                               r_start;
    logic                                               r_valid;
    logic                                               r_ready;
    logic                                               r_bit_en;

    logic [PREC_W-1:0]                                  w_prec_eff;
    logic                                               w_last_plane;
    logic                                               w_sub;
    logic                                               w_all_done;
    logic [N_COL_SA-1:0][N_SA_COLS-1:0][SUM_BITS-1:0]   w_sum;
    logic [N_COL_SA-1:0][N_SA_COLS-1:0][ACC_BITS-1:0]   w_acc_upd;
    logic [N_ROW_SA-1:0][N_SA_ROWS-1:0]                 w_sa_bit;

    for (genvar gc = 0; gc < N_COL_SA; gc++) begin : g_col_sa
        for (genvar gk = 0; gk < N_SA_COLS; gk++) begin : g_out_col
            logic [N_ROW_SA-1:0][ADC_BITS-1:0] w_codes;
            for (genvar gr = 0; gr < N_ROW_SA; gr++) begin : g_row_sa
                assign w_codes[gr] = sa_comp_i[gc][gr][gk];
            end
            pe_adder_tree #(
                .N_IN    (N_ROW_SA),
                .IN_BITS (ADC_BITS),
                .OUT_BITS(SUM_BITS)
            ) u_adder_tree (
                .i_codes(w_codes),
                .o_sum  (w_sum[gc][gk])
            );
        end
    end

    // Out-of-range or zero precision requests fall back to full precision.
    always_comb begin
        if ((prec_i == {PREC_W{1'b0}}) || (prec_i > PREC_W'(MAX_PREC))) begin
            w_prec_eff = PREC_W'(MAX_PREC);
        end else begin
            w_prec_eff = prec_i;
        end
    end

    assign w_last_plane = (PREC_W'(r_b) == (r_prec - PREC_W'(1'b1)));
    assign w_sub        = r_signed && w_last_plane;
    assign w_all_done   = &r_sticky;

    // Next-state decode for the plane sequencing controller.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_all_done) begin
                    w_next_state = ST_ACCUM;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_ACCUM: begin
                if (w_last_plane) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake and strobe outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start  <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_bit_en <= 1'b0;
        end else begin
            r_start  <= (w_next_state == ST_ISSUE);
            r_valid  <= (w_next_state == ST_DONE);
            r_ready  <= (w_next_state == ST_IDLE);
            r_bit_en <= (w_next_state == ST_ISSUE) || (w_next_state == ST_WAIT) ||
                        (w_next_state == ST_ACCUM);
        end
    end

    // Shift-add of every column sum; the sign plane of a signed input subtracts.
    always_comb begin
        w_acc_upd = r_acc;
        for (int c = 0; c < N_COL_SA; c++) begin
            for (int k = 0; k < N_SA_COLS; k++) begin
                if (w_sub) begin
                    w_acc_upd[c][k] = r_acc[c][k] - (ACC_BITS'(w_sum[c][k]) << r_b);
                end else begin
                    w_acc_upd[c][k] = r_acc[c][k] + (ACC_BITS'(w_sum[c][k]) << r_b);
                end
            end
        end
    end

    // Input latch, plane counter, sticky done collection and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_prec   <= '0;
            r_signed <= 1'b0;
            r_b      <= '0;
            r_sticky <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_data   <= in_data_i;
                        r_prec   <= w_prec_eff;
                        r_signed <= signed_i;
                        r_b      <= '0;
                        r_acc    <= '0;
                    end
                end
                ST_ISSUE: r_sticky <= '0;
                ST_WAIT:  r_sticky <= r_sticky | sa_done_i;
                ST_ACCUM: begin
                    r_acc <= w_acc_upd;
                    r_b   <= r_b + B_W'(1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    // Current bit-plane of every latched input, zero outside a conversion.
    always_comb begin
        w_sa_bit = '0;
        if (r_bit_en) begin
            for (int r = 0; r < N_ROW_SA; r++) begin
                for (int i = 0; i < N_SA_ROWS; i++) begin
                    w_sa_bit[r][i] = r_data[r*N_SA_ROWS + i][r_b];
                end
            end
        end else begin
            w_sa_bit = '0;
        end
    end

    assign in_ready_o  = r_ready;
    assign out_valid_o = r_valid;
    assign sa_start_o  = {(N_COL_SA*N_ROW_SA){r_start}};
    assign sa_bit_o    = w_sa_bit;
    assign out_data_o  = r_acc;

endmodule

// File: tb/tb_pe_bitserial_acc.sv
// Scoreboard bench for pe_bitserial_acc: SA responder model, dot-product
// reference computed from the input values, and a decoupled output monitor.
module tb_pe_bitserial_acc;

    localparam int NSR = 4;
    localparam int NRS = 2;
    localparam int NCS = 1;
    localparam int NSC = 2;
    localparam int ADC = 4;
    localparam int MP  = 4;

    typedef struct {
        int v0;
        int v1;
        int nst;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            in_valid_i;
    logic                            in_ready_o;
    logic [7:0][3:0]                 in_data_i;
    logic [2:0]                      prec_i;
    logic                            signed_i;
    logic [1:0][3:0]                 sa_bit_o;
    logic [0:0][1:0]                 sa_start_o;
    logic [0:0][1:0]                 sa_done_i;
    logic [0:0][1:0][1:0][3:0]       sa_comp_i;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic signed [0:0][1:0][9:0]     out_data_o;

    pe_bitserial_acc #(
        .N_SA_ROWS(NSR), .N_ROW_SA(NRS), .N_COL_SA(NCS),
        .N_SA_COLS(NSC), .ADC_BITS(ADC), .MAX_PREC(MP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .prec_i(prec_i), .signed_i(signed_i),
        .sa_bit_o(sa_bit_o), .sa_start_o(sa_start_o),
        .sa_done_i(sa_done_i), .sa_comp_i(sa_comp_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad = 0;
    exp_t            exp_q[$];
    int              mode = 0;
    logic [7:0]      wmask [2];
    int              extra = 0;
    int              dcnt [2];
    int              pidx = 0;
    int              start_cnt = 0;
    logic [7:0][3:0] cur_data = '0;
    int              cyc = 0;
    int              last_start = 0;
    bit              have_prev = 1'b0;
    bit              prev_valid = 1'b0;
    int              last_v0 = 0;

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic int sx(input logic [9:0] v);
        logic signed [9:0] t;
        t = v;
        return int'(t);
    endfunction

    function automatic int eff_p(input int p);
        return ((p == 0) || (p > MP)) ? MP : p;
    endfunction

    // Reference: constant-code mode gives 6 * (sum of plane weights); popcount
    // mode is a binary-weighted dot product of the P-bit input values.
    function automatic int model(input logic [7:0][3:0] d, input int p, input bit s, input int k);
        int pe;
        int acc;
        int val;
        pe = eff_p(p);
        if (mode == 0) begin
            return s ? -(3 * NRS) : (3 * NRS) * ((1 << pe) - 1);
        end
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            val = int'(d[i]) & ((1 << pe) - 1);
            if (s && (((val >> (pe - 1)) & 1) == 1)) val = val - (1 << pe);
            if (wmask[k][i]) acc += val;
        end
        return acc;
    endfunction

    function automatic int exp_gap();
        return 5 + ((extra > 0) ? extra : 0);
    endfunction

    // SA responder: done 2 cycles after start (SA[0][1] later by 'extra'),
    // codes held from start, plane and timing checks on every start.
    always @(negedge clk) begin
        logic [1:0][3:0] expb;
        cyc++;
        if (rst) begin
            dcnt = '{0, 0};
            sa_done_i = '0;
            have_prev = 1'b0;
            prev_valid = 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                sa_done_i[0][r] = 1'b0;
                if (dcnt[r] > 0) begin
                    dcnt[r]--;
                    if (dcnt[r] == 0) sa_done_i[0][r] = 1'b1;
                end
            end
            if (sa_start_o != 2'b00) begin
                chk("start_all_ones", int'(sa_start_o), 3);
                if (pidx < MP) begin
                    for (int r = 0; r < 2; r++)
                        for (int i = 0; i < 4; i++)
                            expb[r][i] = cur_data[r*4 + i][pidx[1:0]];
                    chk("plane_bits", int'(sa_bit_o), int'(expb));
                end else begin
                    chk("plane_count", pidx, MP - 1);
                end
                if (have_prev) chk("start_gap", cyc - last_start, exp_gap());
                have_prev = 1'b1;
                last_start = cyc;
                start_cnt++;
                pidx++;
                dcnt[0] = 2;
                dcnt[1] = 2 + extra;
                for (int r = 0; r < 2; r++)
                    for (int k = 0; k < 2; k++)
                        sa_comp_i[0][r][k] = (mode == 0) ? 4'd3 :
                            4'($countones(sa_bit_o[r] & wmask[k][r*4 +: 4]));
            end
            if (out_valid_o && !prev_valid && have_prev) begin
                chk("done_gap", cyc - last_start, exp_gap());
                have_prev = 1'b0;
            end
            prev_valid = out_valid_o;
        end
    end

    // Monitor: every output handshake pops and compares one scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_col0", sx(out_data_o[0][0]), e.v0);
                chk("out_col1", sx(out_data_o[0][1]), e.v1);
                chk("start_pulses", start_cnt, e.nst);
            end
        end
    end

    task automatic send(input logic [7:0][3:0] d, input int p, input bit s);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        in_data_i  = d;
        prec_i     = 3'(p);
        signed_i   = s;
        in_valid_i = 1'b1;
        cur_data   = d;
        pidx       = 0;
        start_cnt  = 0;
        e.v0  = model(d, p, s, 0);
        e.v1  = model(d, p, s, 1);
        e.nst = eff_p(p);
        last_v0 = e.v0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_data_i  = 32'($urandom);
        prec_i     = 3'($urandom_range(0, 7));
        signed_i   = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
    endtask

    task automatic run(input int p, input bit s);
        send(32'($urandom), p, s);
        wait_idle();
        chk("result_held", sx(out_data_o[0][0]), last_v0);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_start", int'(sa_start_o), 0);
        chk("rst_sa_bit", int'(sa_bit_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_col0", sx(out_data_o[0][0]), 0);
        chk("rst_out_col1", sx(out_data_o[0][1]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int h1;
        int hp;
        int n;
        rst = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        prec_i = 3'd0;
        signed_i = 1'b0;
        out_ready_i = 1'b1;
        sa_comp_i = '0;
        wmask[0] = 8'hFF;
        wmask[1] = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        run(4, 1'b0);
        run(4, 1'b1);
        run(2, 1'b0);
        run(0, 1'b0);
        run(6, 1'b0);
        run(1, 1'b1);
        extra = 5;
        run(4, 1'b0);
        extra = 0;

        mode = 1;
        for (int t = 0; t < 24; t++) begin
            wmask[0] = 8'($urandom);
            wmask[1] = 8'($urandom);
            extra = $urandom_range(0, 3);
            run($urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        extra = 0;

        // Back-pressure: output held, new inputs refused.
        out_ready_i = 1'b0;
        hp = $urandom_range(0, 7);
        send(32'($urandom), hp, 1'b1);
        n = 0;
        while (!out_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", int'(out_valid_o), 1);
        h0 = sx(out_data_o[0][0]);
        h1 = sx(out_data_o[0][1]);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i = 32'($urandom);
            chk("hold_valid", int'(out_valid_o), 1);
            chk("hold_col0", sx(out_data_o[0][0]), h0);
            chk("hold_col1", sx(out_data_o[0][1]), h1);
            chk("hold_in_ready", int'(in_ready_o), 0);
            chk("hold_sa_bit", int'(sa_bit_o), 0);
            chk("hold_starts", start_cnt, eff_p(hp));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_xfer_in_ready", int'(in_ready_o), 1);
        chk("post_xfer_valid", int'(out_valid_o), 0);
        chk("post_xfer_col0", sx(out_data_o[0][0]), h0);

        // Reset while the SAs are converting.
        mode = 0;
        send(32'($urandom), 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        run(3, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
